// File: rtl/evb_timer.sv
// ev-bus timer: prescaled 32-bit down-counter with reload, sticky pending flag and level irq.
// One command is served per request; the FSM waits for request to drop before re-arming.
module evb_timer #(
  parameter logic [11:0] DEV_ID     = 12'h001,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        evb_cmd_request,
  input  logic [15:0] evb_cmd_addr,
  input  logic [1:0]  evb_cmd_wr_mask,
  input  logic [31:0] evb_cmd_wr_data,
  output logic        evb_cmd_finish,
  output logic [31:0] evb_cmd_rd_data,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, RESP, DROP} state_t;

  state_t                state, state_nx;
  logic                  en, auto_rl, ie, pending;
  logic [31:0]           count, reload, rd_q, rd_mux, prescale_wr;
  logic [PRESCALE_W-1:0] prescale, psc_cnt;
  logic                  accept, wr, tick, w1c;
  logic [3:0]            sub;

  function automatic logic [31:0] merge_halves(input logic [31:0] old, input logic [31:0] d,
                                               input logic [1:0] m);
    logic [31:0] r;
    r = old;
    if (m[0]) r[15:0]  = d[15:0];
    if (m[1]) r[31:16] = d[31:16];
    return r;
  endfunction

  assign sub         = evb_cmd_addr[3:0];
  assign accept      = (state == IDLE) && evb_cmd_request && (evb_cmd_addr[15:4] == DEV_ID);
  assign wr          = accept && (evb_cmd_wr_mask != 2'b00);
  assign tick        = en && (psc_cnt == prescale);
  assign w1c         = wr && (sub == 4'd3) && evb_cmd_wr_mask[0] && evb_cmd_wr_data[0];
  assign prescale_wr = merge_halves({{(32-PRESCALE_W){1'b0}}, prescale}, evb_cmd_wr_data,
                                    evb_cmd_wr_mask);

  always_comb begin
    rd_mux = '0;
    case (sub)
      4'd0:    rd_mux = {29'd0, ie, auto_rl, en};
      4'd1:    rd_mux = count;
      4'd2:    rd_mux = reload;
      4'd3:    rd_mux = {31'd0, pending};
      4'd4:    rd_mux = {{(32-PRESCALE_W){1'b0}}, prescale};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RESP;
      RESP:    state_nx = DROP;
      DROP:    if (!evb_cmd_request) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Finish is decoded from state so an async reset drops it immediately.
  assign evb_cmd_finish  = (state == RESP);
  assign evb_cmd_rd_data = evb_cmd_finish ? rd_q : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      pending  <= 1'b0;
      count    <= '0;
      reload   <= '0;
      prescale <= '0;
      psc_cnt  <= '0;
      irq      <= 1'b0;
    end else begin
      if (accept) rd_q <= rd_mux;

      if (!en || tick) psc_cnt <= '0;
      else             psc_cnt <= psc_cnt + 1'b1;

      // Clear precedes the tick block so a same-edge expiry keeps PENDING set.
      if (w1c) pending <= 1'b0;

      if (tick) begin
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else begin
          pending <= 1'b1;
          if (auto_rl) count <= reload;
          else         en    <= 1'b0;
        end
      end

      // Bus writes come last so they override tick updates on the same edge;
      // unwritten COUNT halves keep their pre-tick value.
      if (wr) begin
        case (sub)
          4'd0: if (evb_cmd_wr_mask[0]) {ie, auto_rl, en} <= evb_cmd_wr_data[2:0];
          4'd1: count    <= merge_halves(count, evb_cmd_wr_data, evb_cmd_wr_mask);
          4'd2: reload   <= merge_halves(reload, evb_cmd_wr_data, evb_cmd_wr_mask);
          4'd4: prescale <= prescale_wr[PRESCALE_W-1:0];
          default: ;
        endcase
      end

      irq <= pending & ie;
    end
  end

endmodule

// File: tb/tb_evb_timer.sv
// Directed bench for evb_timer: bus protocol, countdown/reload, W1C collisions, reset mid-command.
module tb_evb_timer;

  localparam logic [11:0] ID = 12'h001;

  logic        clk, rst;
  logic        request;
  logic [15:0] addr;
  logic [1:0]  wr_mask;
  logic [31:0] wr_data;
  logic        finish;
  logic [31:0] rd_data;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  evb_timer #(.DEV_ID(ID), .PRESCALE_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .evb_cmd_request (request),
    .evb_cmd_addr    (addr),
    .evb_cmd_wr_mask (wr_mask),
    .evb_cmd_wr_data (wr_data),
    .evb_cmd_finish  (finish),
    .evb_cmd_rd_data (rd_data),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise request on a falling edge, expect finish one cycle after acceptance
  // and for exactly one cycle; returns on the edge that brings the FSM back to IDLE.
  task automatic bus(input logic [15:0] a, input logic [1:0] m, input logic [31:0] d,
                     output logic [31:0] rd);
    int lat;
    logic fin2;
    @(negedge clk);
    request = 1'b1; addr = a; wr_mask = m; wr_data = d;
    lat = 0; rd = '0;
    do begin
      @(negedge clk);
      lat++;
    end while (!finish && lat < 20);
    if (finish) rd = rd_data;
    check("bus_latency", 32'(lat), 32'd1);
    request = 1'b0; wr_mask = 2'b00; wr_data = '0;
    @(negedge clk);
    fin2 = finish;
    check("finish_one_cycle", 32'(fin2), 32'd0);
    @(posedge clk);
  endtask

  task automatic wreg(input logic [3:0] s, input logic [1:0] m, input logic [31:0] d);
    logic [31:0] x;
    bus({ID, s}, m, d, x);
  endtask

  task automatic rreg(input string tag, input logic [3:0] s, input logic [31:0] exp);
    logic [31:0] x;
    bus({ID, s}, 2'b00, 32'd0, x);
    check(tag, x, exp);
  endtask

  initial begin
    int n;
    logic [31:0] rdv;
    rst = 1'b1; request = 1'b0; addr = '0; wr_mask = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_finish", 32'(finish), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic access, unused sub id, foreign device id
    wreg(4'd0, 2'b11, 32'h0);
    rreg("count_after_reset", 4'd1, 32'h0);
    wreg(4'd7, 2'b11, 32'hFFFF_FFFF);
    rreg("unused_sub_reads_0", 4'd7, 32'h0);
    @(negedge clk);
    request = 1'b1; addr = 16'h0021; wr_mask = 2'b00;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (finish) n++;
    end
    check("foreign_id_no_finish", 32'(n), 32'd0);
    request = 1'b0;
    repeat (2) @(posedge clk);

    // One-shot countdown: ticks every cycle, expiry on the 4th tick
    wreg(4'd4, 2'b11, 32'd0);
    wreg(4'd1, 2'b11, 32'd3);
    wreg(4'd0, 2'b11, 32'h5);
    @(posedge clk);
    @(posedge clk);
    #1 check("oneshot_irq_lags_pending", 32'(irq), 32'd0);
    @(posedge clk);
    #1 check("oneshot_irq_rises", 32'(irq), 32'd1);
    repeat (3) @(posedge clk);
    rreg("oneshot_pending", 4'd3, 32'h1);
    rreg("oneshot_en_cleared", 4'd0, 32'h4);
    rreg("oneshot_count_zero", 4'd1, 32'h0);
    wreg(4'd3, 2'b01, 32'h1);
    rreg("w1c_clears", 4'd3, 32'h0);
    check("w1c_irq_low", 32'(irq), 32'd0);

    // Register fields, partial writes
    wreg(4'd0, 2'b11, 32'hFFFF_FFF8);
    rreg("ctrl_unused_bits", 4'd0, 32'h0);
    wreg(4'd1, 2'b11, 32'h1234_0000);
    wreg(4'd1, 2'b01, 32'hAAAA_5555);
    rreg("count_low_half", 4'd1, 32'h1234_5555);
    wreg(4'd1, 2'b10, 32'hBEEF_0000);
    rreg("count_high_half", 4'd1, 32'hBEEF_5555);
    wreg(4'd2, 2'b11, 32'hCAFE_F00D);
    rreg("reload_rw", 4'd2, 32'hCAFE_F00D);
    wreg(4'd4, 2'b11, 32'hFFFF_0123);
    rreg("prescale_zero_ext", 4'd4, 32'h0000_0123);

    // Partial COUNT write colliding with a tick; upper half keeps pre-tick value
    wreg(4'd4, 2'b11, 32'd0);
    wreg(4'd1, 2'b11, 32'h0007_0010);
    wreg(4'd0, 2'b11, 32'h1);
    wreg(4'd1, 2'b01, 32'h0000_0040);
    wreg(4'd0, 2'b11, 32'h0);
    rreg("count_write_beats_tick", 4'd1, 32'h0007_003D);

    // Auto-reload: prescale 2, reload 1 -> expiry every 6 cycles
    wreg(4'd4, 2'b11, 32'd2);
    wreg(4'd2, 2'b11, 32'd1);
    wreg(4'd1, 2'b11, 32'd0);
    wreg(4'd0, 2'b11, 32'h7);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!irq && n < 20);
    check("auto_first_irq", 32'(n), 32'd2);
    wreg(4'd3, 2'b01, 32'h1);
    #1 check("auto_w1c_irq_drops", 32'(irq), 32'd0);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!irq && n < 20);
    check("auto_irq_reasserts", 32'(n), 32'd3);

    // W1C landing on the expiry edge: set wins
    wreg(4'd3, 2'b01, 32'h1);
    #1 check("pre_collision_irq_low", 32'(irq), 32'd0);
    @(posedge clk);
    wreg(4'd3, 2'b01, 32'h1);
    #1 check("collision_irq_high", 32'(irq), 32'd1);
    rreg("collision_pending", 4'd3, 32'h1);

    // Reset while finish is high, request held across reset
    check("pre_reset_irq", 32'(irq), 32'd1);
    @(negedge clk);
    request = 1'b1; addr = {ID, 4'd1}; wr_mask = 2'b00;
    @(posedge clk);
    #1 check("resp_before_reset", 32'(finish), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("reset_drops_finish", 32'(finish), 32'd0);
    check("reset_drops_irq", 32'(irq), 32'd0);
    check("reset_drops_rd_data", rd_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0; rdv = 32'hDEAD_BEEF;
    repeat (10) begin
      @(negedge clk);
      if (finish) begin
        n++;
        rdv = rd_data;
      end
    end
    check("held_request_once", 32'(n), 32'd1);
    check("held_request_rd", rdv, 32'h0);
    request = 1'b0;
    repeat (2) @(posedge clk);
    rreg("post_reset_ctrl", 4'd0, 32'h0);
    rreg("post_reset_reload", 4'd2, 32'h0);
    rreg("post_reset_status", 4'd3, 32'h0);
    rreg("post_reset_prescale", 4'd4, 32'h0);
    check("post_reset_irq", 32'(irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/evb_timer.md
Name: evb_timer

Overview:
- Timer/interrupt device on the ev bus, directly downstream of the core's ev bus command port.
- Consumes the core's evb_cmd_* transactions and generates the level interrupt that drives the core's irq input.
- Provides a prescaled 32-bit down-counter, a reload register and a sticky pending flag.
- Only responds to commands whose device id matches DEV_ID.

Parameters:
DEV_ID, 12'h001, device id matched against evb_cmd_addr[15:4]
PRESCALE_W, 16, width of prescaler register/counter (1..16)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
evb_cmd_request  input  1  command valid, held by master until finish
evb_cmd_addr  input  16  [15:4] device id, [3:0] sub id
evb_cmd_wr_mask  input  2  00 = read; bit0 writes [15:0], bit1 writes [31:16]
evb_cmd_wr_data  input  32  write data
evb_cmd_finish  output  1  one-cycle completion pulse
evb_cmd_rd_data  output  32  read data, valid while finish=1, else 0
irq  output  1  interrupt level to core

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - finish=0, rd_data=0, irq=0.
  - CTRL=0, COUNT=0, RELOAD=0, PENDING=0, PRESCALE=0, prescale counter=0.
  - Bus FSM goes to IDLE.
- Register map (sub id):
  - 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); other bits read 0.
  - 1 COUNT: 32 bits.
  - 2 RELOAD: 32 bits.
  - 3 STATUS: bit0 PENDING; write 1 clears, write 0 has no effect.
  - 4 PRESCALE: PRESCALE_W bits, zero-extended on read.
  - 5..15: read 0, writes ignored (still completed).
- Bus FSM, states IDLE, RESP, DROP:
  - IDLE: request=1 and addr[15:4]==DEV_ID → accept. Write performed at this clock edge with byte-lane mask per wr_mask half. Read data captured from the register value before any same-edge update. Go to RESP.
  - RESP: finish=1 and rd_data driven for exactly one cycle; go to DROP.
  - DROP: ignore request; return to IDLE when request=0. A request still high is not re-accepted, so each command completes exactly once.
  - Request with non-matching id: never accepted; finish stays 0.
  - Latency: finish is asserted in the cycle after acceptance (1 cycle).
- Prescaler:
  - When EN=1, prescale counter increments each clk.
  - When counter==PRESCALE, a tick is generated and the counter returns to 0. PRESCALE=0 gives a tick every cycle.
  - EN=0 holds the counter at 0.
- Tick handling:
  - COUNT!=0 → COUNT-1.
  - COUNT==0 → PENDING set. If AUTO=1, COUNT←RELOAD; else EN←0 and COUNT stays 0.
- Simultaneous events:
  - Bus write to COUNT on a tick edge: written value wins, no decrement.
  - Write to CTRL on the tick edge that clears EN: written value wins.
  - Tick sets PENDING on the same edge as a STATUS W1C: set wins.
  - Partial writes (wr_mask 01/10) update only the selected half; on the COUNT/tick collision the unwritten half keeps its pre-tick value.
- irq:
  - Registered: irq ← PENDING & IE, so it appears one cycle after PENDING rises.
  - Level-held until PENDING is cleared or IE=0.
- Reset mid-transaction: FSM returns to IDLE and finish drops immediately. The master reissues the command.

Test Plan:
- Write CTRL=0x0 then read sub 1 at DEV_ID → finish exactly 1 cycle after acceptance, rd_data=0; non-matching id 0x002 → finish never asserted over 20 cycles.
- PRESCALE=0, COUNT=3, CTRL=0x5 (EN,IE) → PENDING set on 4th tick; irq=1 one cycle later; EN reads 0; COUNT reads 0.
- PRESCALE=2, RELOAD=1, COUNT=0, CTRL=0x7 → PENDING every 6 cycles. Write STATUS=1 → irq drops; it reasserts after the next expiry.
- Write COUNT low half only (wr_mask=01, data 0xAAAA5555) with COUNT=0x12340000 and EN=0 → COUNT reads 0x12345555.
- STATUS W1C issued on the same edge as expiry → PENDING stays 1, irq stays 1.
- Assert rst during RESP → finish=0 and irq=0 within the same cycle. All registers read 0 after reset; a request held high across reset is accepted once.
